// File: rtl/ans_ht_stf_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ans_ht_stf_detector                                           |
// | Purpose  : HT-STF detector. It computes the delay-16 autocorrelation C   |
// |            and the window power P over 16 samples. A plateau FSM then    |
// |            turns the run of threshold hits into detect/done events for   |
// |            the RX control FSM.                                           |
// | Ports    : clk, reset_n (async, active-low), clear (sync flush)          |
// |            sample_in {I,Q} s16 + sample_valid (no backpressure)          |
// |            stf_detected / stf_done pulses, stf_active level              |
// |            det_index (first hit index), plateau_len (saturating hits)    |
// | Option   : ANS_STF_CFO_EN adds cfo_re/cfo_im. These hold C captured at   |
// |            the detection.                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ans_ht_stf_detector #(
  parameter int THRESH_NUM  = 12,
  parameter int MIN_PLATEAU = 48,
  parameter int MIN_POWER   = 4096,
  parameter int HOLDOFF     = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [31:0] sample_in,
  input  logic        sample_valid,
  output logic        stf_detected,
  output logic        stf_active,
  output logic        stf_done,
  output logic [15:0] det_index,
  output logic [7:0]  plateau_len
`ifdef ANS_STF_CFO_EN
  ,
  output logic [36:0] cfo_re,
  output logic [36:0] cfo_im
`endif
);

  localparam logic [2:0]  S_FILL      = 3'd0;
  localparam logic [2:0]  S_SEARCH    = 3'd1;
  localparam logic [2:0]  S_PLATEAU   = 3'd2;
  localparam logic [2:0]  S_LOCKED    = 3'd3;
  localparam logic [2:0]  S_HOLDOFF   = 3'd4;
  localparam logic [41:0] THRESH_W    = 42'(THRESH_NUM);
  localparam logic [36:0] MIN_POWER_W = 37'(MIN_POWER);
  localparam logic [7:0]  MIN_PLAT_W  = 8'(MIN_PLATEAU);
  localparam logic [15:0] HOLDOFF_W   = 16'(HOLDOFF);

  // Stage A: delay line and products; B: window sums; C: hit; D: FSM.
  logic [15:0] n_q, n_d, na_q, na_d, nb_q, nb_d, nc_q, nc_d;
  logic [31:0] dly_q [16];
  logic [31:0] dly_d [16];
  logic        va_q, va_d, vb_q, vb_d, vc_q, vc_d;
  logic [32:0] p_re_q, p_re_d, p_im_q, p_im_d, pw_q, pw_d;
  logic [32:0] hre_q [16];
  logic [32:0] hre_d [16];
  logic [32:0] him_q [16];
  logic [32:0] him_d [16];
  logic [32:0] hpw_q [16];
  logic [32:0] hpw_d [16];
  logic [36:0] c_re_q, c_re_d, c_im_q, c_im_d, sp_q, sp_d;
  logic        hit_q, hit_d;
  logic [2:0]  state_q, state_d, st_eff;
  logic [7:0]  run_q, run_d, run_nx;
  logic [15:0] start_q, start_d, hold_q, hold_d, hold_nx;
  logic        det_q, det_d, done_q, done_d, active_q, active_d;
  logic [15:0] didx_q, didx_d;
  logic [7:0]  plen_q, plen_d;
`ifdef ANS_STF_CFO_EN
  logic [36:0] cc_re_q, cc_re_d, cc_im_q, cc_im_d;
  logic [36:0] cfo_re_q, cfo_re_d, cfo_im_q, cfo_im_d;
`endif

  // Products s[n]*conj(s[n-16]) and |s[n-16]|^2.
  logic signed [15:0] s_i, s_q, o_i, o_q;
  logic signed [31:0] m_ii, m_qq, m_qi, m_iq, m_oi, m_oq;
  assign s_i  = sample_in[31:16];
  assign s_q  = sample_in[15:0];
  assign o_i  = dly_q[15][31:16];
  assign o_q  = dly_q[15][15:0];
  assign m_ii = s_i * o_i;
  assign m_qq = s_q * o_q;
  assign m_qi = s_q * o_i;
  assign m_iq = s_i * o_q;
  assign m_oi = o_i * o_i;
  assign m_oq = o_q * o_q;

  // Threshold test at full width: (|Re|+|Im|)*16 >= P*THRESH_NUM.
  logic [36:0] abs_re, abs_im;
  logic [41:0] lhs, rhs;
  logic        hit_w;
  assign abs_re = c_re_q[36] ? (~c_re_q + 37'd1) : c_re_q;
  assign abs_im = c_im_q[36] ? (~c_im_q + 37'd1) : c_im_q;
  assign lhs    = ({5'd0, abs_re} + {5'd0, abs_im}) << 4;
  assign rhs    = {5'd0, sp_q} * THRESH_W;
  assign hit_w  = (lhs >= rhs) && (sp_q >= MIN_POWER_W);

  always_comb begin
    n_d = n_q;  na_d = na_q;  nb_d = nb_q;  nc_d = nc_q;
    dly_d = dly_q;  hre_d = hre_q;  him_d = him_q;  hpw_d = hpw_q;
    va_d = 1'b0;  vb_d = 1'b0;  vc_d = 1'b0;
    p_re_d = p_re_q;  p_im_d = p_im_q;  pw_d = pw_q;
    c_re_d = c_re_q;  c_im_d = c_im_q;  sp_d = sp_q;  hit_d = hit_q;
    state_d = state_q;  st_eff = state_q;  run_d = run_q;  run_nx = run_q;
    start_d = start_q;  hold_d = hold_q;  hold_nx = hold_q;
    det_d = 1'b0;  done_d = 1'b0;  active_d = active_q;
    didx_d = didx_q;  plen_d = plen_q;
`ifdef ANS_STF_CFO_EN
    cc_re_d = cc_re_q;  cc_im_d = cc_im_q;
    cfo_re_d = cfo_re_q;  cfo_im_d = cfo_im_q;
`endif
    // Stage A
    if (sample_valid) begin
      dly_d[0] = sample_in;
      for (int k = 1; k < 16; k++) dly_d[k] = dly_q[k-1];
      p_re_d = {m_ii[31], m_ii} + {m_qq[31], m_qq};
      p_im_d = {m_qi[31], m_qi} - {m_iq[31], m_iq};
      pw_d   = {1'b0, m_oi} + {1'b0, m_oq};
      na_d   = n_q;
      va_d   = 1'b1;
      n_d    = n_q + 16'd1;
    end
    // Stage B: add the newest product, drop the one 16 samples older.
    if (va_q) begin
      c_re_d = c_re_q + {{4{p_re_q[32]}}, p_re_q} - {{4{hre_q[15][32]}}, hre_q[15]};
      c_im_d = c_im_q + {{4{p_im_q[32]}}, p_im_q} - {{4{him_q[15][32]}}, him_q[15]};
      sp_d   = sp_q + {4'd0, pw_q} - {4'd0, hpw_q[15]};
      hre_d[0] = p_re_q;  him_d[0] = p_im_q;  hpw_d[0] = pw_q;
      for (int k = 1; k < 16; k++) begin
        hre_d[k] = hre_q[k-1];  him_d[k] = him_q[k-1];  hpw_d[k] = hpw_q[k-1];
      end
      nb_d = na_q;
      vb_d = 1'b1;
    end
    // Stage C
    if (vb_q) begin
      hit_d = hit_w;
      nc_d  = nb_q;
      vc_d  = 1'b1;
`ifdef ANS_STF_CFO_EN
      cc_re_d = c_re_q;  cc_im_d = c_im_q;
`endif
    end
    // Stage D: the n=31 evaluation in S_FILL behaves as a search step.
    if (vc_q) begin
      if (state_q == S_FILL) st_eff = (nc_q == 16'd31) ? S_SEARCH : S_FILL;
      state_d = st_eff;
      case (st_eff)
        S_SEARCH, S_PLATEAU: begin
          if (hit_q) begin
            run_nx = (st_eff == S_SEARCH) ? 8'd1 : run_q + 8'd1;
            run_d  = run_nx;
            if (st_eff == S_SEARCH) start_d = nc_q;
            if (run_nx >= MIN_PLAT_W) begin
              det_d    = 1'b1;
              active_d = 1'b1;
              didx_d   = (st_eff == S_SEARCH) ? nc_q : start_q;
              state_d  = S_LOCKED;
`ifdef ANS_STF_CFO_EN
              cfo_re_d = cc_re_q;  cfo_im_d = cc_im_q;
`endif
            end else begin
              state_d = S_PLATEAU;
            end
          end else begin
            state_d = S_SEARCH;
          end
        end
        S_LOCKED: begin
          if (hit_q) begin
            run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
          end else begin
            done_d   = 1'b1;
            plen_d   = run_q;
            active_d = 1'b0;
            hold_d   = 16'd0;
            state_d  = (HOLDOFF_W == 16'd0) ? S_SEARCH : S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          hold_nx = hold_q + 16'd1;
          hold_d  = hold_nx;
          if (hold_nx >= HOLDOFF_W) state_d = S_SEARCH;
        end
        default: state_d = st_eff;
      endcase
    end
    // Flush wins over everything, including tokens still in the pipeline.
    if (clear) begin
      n_d = '0;  na_d = '0;  nb_d = '0;  nc_d = '0;
      dly_d = '{default: '0};  hre_d = '{default: '0};
      him_d = '{default: '0};  hpw_d = '{default: '0};
      va_d = 1'b0;  vb_d = 1'b0;  vc_d = 1'b0;
      p_re_d = '0;  p_im_d = '0;  pw_d = '0;
      c_re_d = '0;  c_im_d = '0;  sp_d = '0;  hit_d = 1'b0;
      state_d = S_FILL;  run_d = '0;  start_d = '0;  hold_d = '0;
      det_d = 1'b0;  done_d = 1'b0;  active_d = 1'b0;  didx_d = '0;  plen_d = '0;
`ifdef ANS_STF_CFO_EN
      cc_re_d = '0;  cc_im_d = '0;  cfo_re_d = '0;  cfo_im_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q <= '0;  na_q <= '0;  nb_q <= '0;  nc_q <= '0;
      dly_q <= '{default: '0};  hre_q <= '{default: '0};
      him_q <= '{default: '0};  hpw_q <= '{default: '0};
      va_q <= 1'b0;  vb_q <= 1'b0;  vc_q <= 1'b0;
      p_re_q <= '0;  p_im_q <= '0;  pw_q <= '0;
      c_re_q <= '0;  c_im_q <= '0;  sp_q <= '0;  hit_q <= 1'b0;
      state_q <= S_FILL;  run_q <= '0;  start_q <= '0;  hold_q <= '0;
      det_q <= 1'b0;  done_q <= 1'b0;  active_q <= 1'b0;  didx_q <= '0;  plen_q <= '0;
`ifdef ANS_STF_CFO_EN
      cc_re_q <= '0;  cc_im_q <= '0;  cfo_re_q <= '0;  cfo_im_q <= '0;
`endif
    end else begin
      n_q <= n_d;  na_q <= na_d;  nb_q <= nb_d;  nc_q <= nc_d;
      dly_q <= dly_d;  hre_q <= hre_d;  him_q <= him_d;  hpw_q <= hpw_d;
      va_q <= va_d;  vb_q <= vb_d;  vc_q <= vc_d;
      p_re_q <= p_re_d;  p_im_q <= p_im_d;  pw_q <= pw_d;
      c_re_q <= c_re_d;  c_im_q <= c_im_d;  sp_q <= sp_d;  hit_q <= hit_d;
      state_q <= state_d;  run_q <= run_d;  start_q <= start_d;  hold_q <= hold_d;
      det_q <= det_d;  done_q <= done_d;  active_q <= active_d;
      didx_q <= didx_d;  plen_q <= plen_d;
`ifdef ANS_STF_CFO_EN
      cc_re_q <= cc_re_d;  cc_im_q <= cc_im_d;  cfo_re_q <= cfo_re_d;  cfo_im_q <= cfo_im_d;
`endif
    end
  end

  assign stf_detected = det_q;
  assign stf_done     = done_q;
  assign stf_active   = active_q;
  assign det_index    = didx_q;
  assign plateau_len  = plen_q;
`ifdef ANS_STF_CFO_EN
  assign cfo_re = cfo_re_q;
  assign cfo_im = cfo_im_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ans_ht_stf_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ans_ht_stf_detector                                        |
// | Purpose  : Self-checking bench for ans_ht_stf_detector. It uses a table  |
// |            of stream vectors plus hand-written reset/clear sequences.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ans_ht_stf_detector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        stf_detected, stf_active, stf_done;
  logic [15:0] det_index;
  logic [7:0]  plateau_len;
`ifdef ANS_STF_CFO_EN
  logic [36:0] cfo_re, cfo_im;
`endif

  always #5 clk = ~clk;

  ans_ht_stf_detector dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .stf_detected (stf_detected),
    .stf_active   (stf_active),
    .stf_done     (stf_done),
    .det_index    (det_index),
    .plateau_len  (plateau_len)
`ifdef ANS_STF_CFO_EN
    ,
    .cfo_re       (cfo_re),
    .cfo_im       (cfo_im)
`endif
  );

  typedef struct {
    logic [15:0] iv;
    logic [15:0] qv;
    int nsig;
    int ntot;
    bit gap;
    int e_det;
    int e_dn;
    int e_idx;
    int e_done;
    int e_don;
    int e_plen;
  } vec_t;

  localparam int HN = 8192;
  localparam int NV = 11;
  vec_t tv [NV];
  int   edge_n [HN];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, n_acc = 0;
  int   det_cnt, det_n, done_cnt, done_n, pulse_bad, active_bad, act_hi;
  logic [15:0] det_idx_v;
  logic [7:0]  plen_v;
  logic prev_det = 1'b0, prev_done = 1'b0, exp_act = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    det_cnt = 0;  det_n = -1;  done_cnt = 0;  done_n = -1;
    pulse_bad = 0;  active_bad = 0;  act_hi = 0;
    det_idx_v = '0;  plen_v = '0;
  endtask

  // One clock: drive, let the edge happen, then observe at the falling edge.
  task automatic step(input logic v, input logic [31:0] d, input logic c);
    sample_valid = v;  sample_in = d;  clear = c;
    @(posedge clk);
    cyc++;
    edge_n[cyc % HN] = (v && !c && reset_n) ? n_acc : -1;
    if (c) n_acc = 0;
    else if (v && reset_n) n_acc++;
    @(negedge clk);
    if (c || !reset_n) exp_act = 1'b0;
    if (stf_detected) begin
      det_cnt++;
      det_idx_v = det_index;
      if (det_n < 0 && cyc >= 3) det_n = edge_n[(cyc - 3) % HN];
      exp_act = 1'b1;
    end
    if (stf_done) begin
      done_cnt++;
      plen_v = plateau_len;
      if (done_n < 0 && cyc >= 3) done_n = edge_n[(cyc - 3) % HN];
      exp_act = 1'b0;
    end
    if ((stf_detected && prev_det) || (stf_done && prev_done)) pulse_bad++;
    if (stf_active !== exp_act) active_bad++;
    if (stf_active) act_hi++;
    prev_det = stf_detected;  prev_done = stf_done;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_act = 1'b0;
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    reset_n = 1'b1;
    n_acc = 0;
  endtask

  // nsig periodic samples then zeros, ntot accepted samples total.
  task automatic run_vec(input logic [15:0] iv, input logic [15:0] qv,
                         input int nsig, input int ntot, input bit gap);
    for (int k = 0; k < ntot; k++) begin
      step(1'b1, (k < nsig) ? {iv, qv} : 32'd0, 1'b0);
      if (gap) step(1'b0, $urandom, 1'b0);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: got 0 expected 1 (simulation time limit)");
    $fatal(1, "timeout");
  end

  initial begin
    //        I        Q        nsig ntot gap det dn  idx done don plen
    tv[0]  = '{16'd1000, 16'd0,    160, 300, 1'b0, 1, 78, 31, 1, 164, 133};
    tv[1]  = '{16'd10,   16'd0,    200, 260, 1'b0, 0, -1,  0, 0,  -1,   0};
    tv[2]  = '{16'd1000, 16'd0,     60, 200, 1'b0, 0, -1,  0, 0,  -1,   0};
    tv[3]  = '{16'd1000, 16'd0,    160, 300, 1'b1, 1, -1, 31, 1,  -1, 133};
    tv[4]  = '{16'hFC18, 16'd0,    160, 300, 1'b0, 1, 78, 31, 1, 164, 133};
    tv[5]  = '{16'd0,    16'd1000, 160, 300, 1'b0, 1, 78, 31, 1, 164, 133};
    tv[6]  = '{16'hFD44, 16'h02BC, 160, 300, 1'b0, 1, 78, 31, 1, 164, 133};
    tv[7]  = '{16'd1000, 16'd0,     75, 200, 1'b0, 1, 78, 31, 1,  79,  48};
    tv[8]  = '{16'd1000, 16'd0,     74, 200, 1'b0, 0, -1,  0, 0,  -1,   0};
    tv[9]  = '{16'd16,   16'd0,    160, 300, 1'b0, 1, 78, 31, 1, 164, 133};
    tv[10] = '{16'd15,   16'd0,    160, 300, 1'b0, 0, -1,  0, 0,  -1,   0};
    for (int i = 0; i < HN; i++) edge_n[i] = -1;

    // Reset held with random traffic: every output must stay at zero.
    begin
      int bad;
      bad = 0;
      reset_n = 1'b0;
      clear_stats();
      for (int k = 0; k < 20; k++) begin
        step(1'b1, $urandom, 1'b0);
        if (stf_detected || stf_active || stf_done || det_index != 0 || plateau_len != 0) bad++;
      end
      check("reset outputs nonzero cycles", bad, 0);
      check("reset det_index", det_index, 0);
      check("reset plateau_len", plateau_len, 0);
      check("reset stf_active", stf_active, 0);
      reset_n = 1'b1;
      n_acc = 0;
    end

    for (int r = 0; r < NV; r++) begin
      if (r % 2 == 0) do_reset();
      else step(1'b0, 32'd0, 1'b1);
      clear_stats();
      run_vec(tv[r].iv, tv[r].qv, tv[r].nsig, tv[r].ntot, tv[r].gap);
      check($sformatf("v%0d det_count", r), det_cnt, tv[r].e_det);
      check($sformatf("v%0d done_count", r), done_cnt, tv[r].e_done);
      check($sformatf("v%0d pulse_width", r), pulse_bad, 0);
      check($sformatf("v%0d active_track", r), active_bad, 0);
      if (tv[r].e_det > 0) check($sformatf("v%0d det_index", r), det_idx_v, tv[r].e_idx);
      if (tv[r].e_dn >= 0) check($sformatf("v%0d det_sample", r), det_n, tv[r].e_dn);
      if (tv[r].e_done > 0) check($sformatf("v%0d plateau_len", r), plen_v, tv[r].e_plen);
      if (tv[r].e_don >= 0) begin
        check($sformatf("v%0d done_sample", r), done_n, tv[r].e_don);
        check($sformatf("v%0d active_cycles", r), act_hi, tv[r].e_don - tv[r].e_dn);
      end
    end

    // clear at n=100 while locked: active drops, no done from in-flight data.
    do_reset();
    clear_stats();
    for (int k = 0; k < 100; k++) step(1'b1, {16'd1000, 16'd0}, 1'b0);
    check("clr pre det_count", det_cnt, 1);
    check("clr pre active", stf_active, 1);
    step(1'b1, {16'd1000, 16'd0}, 1'b1);
    check("clr active drop", stf_active, 0);
    for (int k = 0; k < 10; k++) step(1'b0, $urandom, 1'b0);
    check("clr no done", done_cnt, 0);
    check("clr no extra det", det_cnt, 1);
    clear_stats();
    run_vec(16'd1000, 16'd0, 160, 300, 1'b0);
    check("clr redetect sample", det_n, 78);
    check("clr redetect index", det_idx_v, 31);
    check("clr redetect plateau_len", plen_v, 133);
    check("clr redetect done_count", done_cnt, 1);
`ifdef ANS_STF_CFO_EN
    check("cfo_re held", cfo_re, 37'd16000000);
    check("cfo_im held", cfo_im, 0);
`endif

    // Async reset mid-plateau: outputs fall before the next clock edge.
    do_reset();
    clear_stats();
    for (int k = 0; k < 100; k++) step(1'b1, {16'd1000, 16'd0}, 1'b0);
    check("arst pre active", stf_active, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst active drop", stf_active, 0);
    check("arst det_index drop", det_index, 0);
    exp_act = 1'b0;
    step(1'b1, {16'd1000, 16'd0}, 1'b0);
    step(1'b1, {16'd1000, 16'd0}, 1'b0);
    reset_n = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 6; k++) step(1'b0, 32'd0, 1'b0);
    check("arst no done", done_cnt, 0);
    clear_stats();
    run_vec(16'd1000, 16'd0, 160, 300, 1'b0);
    check("arst redetect sample", det_n, 78);
    check("arst redetect index", det_idx_v, 31);
    check("arst redetect plateau_len", plen_v, 133);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
